// File: rtl/pulse_cond.sv
// pulse_cond: turns the raw heart-beat sensor input into a clean one-clock beat strobe.
// Define PULSE_INTERVAL_EN to add the beat-to-beat interval (ms) outputs.
module pulse_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REFRACT_CYCLES  = 25000000,
  parameter int unsigned TIMEOUT_CYCLES  = 300000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pulso_raw,
  output logic       pulse_level,
  output logic       beat,
  output logic       rejected,
  output logic       lost,
  output logic [1:0] state_dbg
`ifdef PULSE_INTERVAL_EN
  ,
  output logic [15:0] interval,
  output logic        interval_valid
`endif
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ARMED   = 2'b01;
  localparam logic [1:0] REFRACT = 2'b10;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] refr_cnt_q, refr_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       state_q, state_d;
  logic             beat_q, beat_d;
  logic             rej_q, rej_d;
  logic             lost_q, lost_d;
  logic             rise;
  logic             tmo_sat;

  // Synchronizer and debounce run regardless of enable so pulse_level stays valid.
  always_comb begin
    sync_d      = {sync_q[0], pulso_raw};
    level_d     = level_q;
    deb_cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (deb_cnt_q == DEB_LAST) level_d = sync_q[1];
      else                       deb_cnt_d = deb_cnt_q + CNT_W'(1);
    end
    level_dly_d = level_q;
  end

  assign rise    = level_q & ~level_dly_q;
  assign tmo_sat = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    refr_cnt_d = refr_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    lost_d     = lost_q;
    beat_d     = 1'b0;
    rej_d      = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      refr_cnt_d = '0;
      tmo_cnt_d  = '0;
      lost_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARMED;
          refr_cnt_d = '0;
          tmo_cnt_d  = '0;
          lost_d     = 1'b0;
        end
        ARMED: begin
          // An accepted beat outranks a timeout landing on the same clock.
          if (rise) begin
            beat_d     = 1'b1;
            state_d    = REFRACT;
            refr_cnt_d = '0;
            tmo_cnt_d  = '0;
            lost_d     = 1'b0;
          end else if (tmo_sat) begin
            lost_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          end
        end
        REFRACT: begin
          rej_d = rise;
          if (tmo_sat) lost_d = 1'b1;
          else         tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          if (refr_cnt_q == REF_LAST) begin
            state_d    = ARMED;
            refr_cnt_d = '0;
          end else begin
            refr_cnt_d = refr_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          refr_cnt_d = '0;
          tmo_cnt_d  = '0;
          lost_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      deb_cnt_q   <= '0;
      refr_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      state_q     <= IDLE;
      beat_q      <= 1'b0;
      rej_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      deb_cnt_q   <= deb_cnt_d;
      refr_cnt_q  <= refr_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      state_q     <= state_d;
      beat_q      <= beat_d;
      rej_q       <= rej_d;
      lost_q      <= lost_d;
    end
  end

  assign pulse_level = level_q;
  assign beat        = beat_q;
  assign rejected    = rej_q;
  assign lost        = lost_q;
  assign state_dbg   = state_q;

`ifdef PULSE_INTERVAL_EN
  localparam int unsigned  MS_CYCLES = 100000;
  localparam logic [16:0]  MS_LAST   = 17'(MS_CYCLES - 1);

  logic [16:0] ms_cnt_q, ms_cnt_d;
  logic [15:0] ival_cnt_q, ival_cnt_d;
  logic [15:0] interval_q, interval_d;
  logic        ival_valid_q, ival_valid_d;
  logic        have_prev_q, have_prev_d;

  // Interval is measured from beat to beat; the first beat after enable only starts timing.
  always_comb begin
    ms_cnt_d     = ms_cnt_q;
    ival_cnt_d   = ival_cnt_q;
    interval_d   = interval_q;
    ival_valid_d = 1'b0;
    have_prev_d  = have_prev_q;
    if (!enable) begin
      ms_cnt_d    = '0;
      ival_cnt_d  = '0;
      have_prev_d = 1'b0;
    end else if (beat_d) begin
      if (have_prev_q) begin
        interval_d   = ival_cnt_q;
        ival_valid_d = 1'b1;
      end
      have_prev_d = 1'b1;
      ms_cnt_d    = '0;
      ival_cnt_d  = '0;
    end else if (ms_cnt_q == MS_LAST) begin
      ms_cnt_d = '0;
      if (ival_cnt_q != '1) ival_cnt_d = ival_cnt_q + 16'd1;
    end else begin
      ms_cnt_d = ms_cnt_q + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms_cnt_q     <= '0;
      ival_cnt_q   <= '0;
      interval_q   <= '0;
      ival_valid_q <= 1'b0;
      have_prev_q  <= 1'b0;
    end else begin
      ms_cnt_q     <= ms_cnt_d;
      ival_cnt_q   <= ival_cnt_d;
      interval_q   <= interval_d;
      ival_valid_q <= ival_valid_d;
      have_prev_q  <= have_prev_d;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = ival_valid_q;
`endif

endmodule

// File: tb/tb_pulse_cond.sv
// Self-checking bench for pulse_cond: constant vector table, corner sequences,
// and random stimulus against a timestamp-based reference model.
module tb_pulse_cond;
  localparam int DEB  = 4;
  localparam int REFR = 20;
  localparam int TMO  = 100;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       pulso_raw;
  logic       pulse_level;
  logic       beat;
  logic       rejected;
  logic       lost;
  logic [1:0] state_dbg;
`ifdef PULSE_INTERVAL_EN
  logic [15:0] interval;
  logic        interval_valid;
`endif

  pulse_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .REFRACT_CYCLES (REFR),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pulso_raw  (pulso_raw),
    .pulse_level(pulse_level),
    .beat       (beat),
    .rejected   (rejected),
    .lost       (lost),
    .state_dbg  (state_dbg)
`ifdef PULSE_INTERVAL_EN
    ,
    .interval      (interval),
    .interval_valid(interval_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int e = 0;

  // Reference model: level from a window of synchronized samples, FSM from timestamps.
  logic m_s1, m_s2, m_lvl, m_lvl_d;
  logic m_win[$];
  bit   m_active, m_have_beat;
  int   m_ref, m_beat_e;
  logic m_beat, m_rej, m_lost;

  typedef struct {
    int         cyc;
    logic       en;
    logic       raw;
    logic       lvl;
    logic       bt;
    logic       rj;
    logic       ls;
    logic [1:0] st;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", nm, e, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", nm, e, act, exp);
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!m_active) return 2'b00;
    if (m_have_beat && (e - m_beat_e < REFR)) return 2'b10;
    return 2'b01;
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_lvl_d = 1'b0;
    m_win.delete();
    m_active = 1'b0; m_have_beat = 1'b0;
    m_ref = 0; m_beat_e = 0;
    m_beat = 1'b0; m_rej = 1'b0; m_lost = 1'b0;
  endtask

  task automatic model_edge();
    logic rise, all_diff;
    rise = m_lvl & ~m_lvl_d;
    m_win.push_back(m_s2);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    all_diff = (m_win.size() == DEB);
    foreach (m_win[i]) if (m_win[i] == m_lvl) all_diff = 1'b0;
    m_s2 = m_s1;
    m_s1 = pulso_raw;
    m_lvl_d = m_lvl;
    if (all_diff) m_lvl = ~m_lvl;
    m_beat = 1'b0;
    m_rej  = 1'b0;
    if (!enable) begin
      m_active = 1'b0; m_have_beat = 1'b0; m_lost = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_ref = e;
    end else begin
      if (rise && m_have_beat && (e - m_beat_e <= REFR)) m_rej = 1'b1;
      else if (rise) begin
        m_beat = 1'b1; m_have_beat = 1'b1; m_beat_e = e; m_ref = e; m_lost = 1'b0;
      end
      if (!m_beat && (e - m_ref >= TMO)) m_lost = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      e++;
      model_edge();
    end
    #1;
    chk("level",    {1'b0, pulse_level}, {1'b0, m_lvl});
    chk("beat",     {1'b0, beat},        {1'b0, m_beat});
    chk("rejected", {1'b0, rejected},    {1'b0, m_rej});
    chk("lost",     {1'b0, lost},        {1'b0, m_lost});
    chk("state",    state_dbg,           m_state());
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (e < n && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic add(input int c, input int en, input int raw, input int lvl,
                     input int bt, input int rj, input int ls, input int st);
    vec_t v;
    v.cyc = c; v.en = (en != 0); v.raw = (raw != 0); v.lvl = (lvl != 0);
    v.bt = (bt != 0); v.rj = (rj != 0); v.ls = (ls != 0); v.st = 2'(st);
    vecs.push_back(v);
  endtask

  // Three 4-clock pulses at r, r+o2, r+o3; their rises land 6 edges after each start.
  task automatic run_trio(input int o2, input int o3, input bit b2, input bit b3,
                          input logic [1:0] st2);
    int r, t1, t2, t3;
    bit eb, er;
    goto(e + REFR + 6);
    r  = e + 1;
    t1 = r + 6; t2 = r + o2 + 6; t3 = r + o3 + 6;
    for (int k = r; k <= t3 + 4; k++) begin
      pulso_raw = ((k - r) < 4) || ((k - r) >= o2 && (k - r) < o2 + 4) ||
                  ((k - r) >= o3 && (k - r) < o3 + 4);
      tick();
      eb = (k == t1) || (k == t2 && b2) || (k == t3 && b3);
      er = (k == t2 && !b2) || (k == t3 && !b3);
      chk("trio_beat", {1'b0, beat},     {1'b0, eb});
      chk("trio_rej",  {1'b0, rejected}, {1'b0, er});
      if (k == t1) chk("trio_state_t1", state_dbg, 2'b10);
      if (k == t2) chk("trio_state_t2", state_dbg, st2);
    end
    pulso_raw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, lat, hold;
    bit found;
    rst = 1'b1; enable = 1'b0; pulso_raw = 1'b0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst0_level", {1'b0, pulse_level}, 2'b00);
    chk("rst0_beat",  {1'b0, beat},        2'b00);
    chk("rst0_lost",  {1'b0, lost},        2'b00);
    chk("rst0_state", state_dbg,           2'b00);
    repeat (3) tick();
    rst = 1'b1;
    e = 0;

    //  cyc  en raw lvl beat rej lost state  (inputs present from this edge on)
    add(  1, 0, 0, 0, 0, 0, 0, 0);
    add(  4, 0, 0, 0, 0, 0, 0, 0);
    add(  5, 1, 0, 0, 0, 0, 0, 1);
    add( 11, 1, 1, 0, 0, 0, 0, 1);
    add( 15, 1, 1, 0, 0, 0, 0, 1);
    add( 16, 1, 1, 1, 0, 0, 0, 1);
    add( 17, 1, 1, 1, 1, 0, 0, 2);
    add( 18, 1, 1, 1, 0, 0, 0, 2);
    add( 36, 1, 1, 1, 0, 0, 0, 2);
    add( 37, 1, 1, 1, 0, 0, 0, 1);
    add( 41, 1, 0, 1, 0, 0, 0, 1);
    add( 45, 1, 0, 1, 0, 0, 0, 1);
    add( 46, 1, 0, 0, 0, 0, 0, 1);
    add( 50, 1, 1, 0, 0, 0, 0, 1);
    add( 53, 1, 0, 0, 0, 0, 0, 1);
    add( 60, 1, 0, 0, 0, 0, 0, 1);
    add(116, 1, 0, 0, 0, 0, 0, 1);
    add(117, 1, 0, 0, 0, 0, 1, 1);
    add(120, 1, 1, 0, 0, 0, 1, 1);
    add(125, 1, 1, 1, 0, 0, 1, 1);
    add(126, 1, 1, 1, 1, 0, 0, 2);
    add(128, 1, 0, 1, 0, 0, 0, 2);
    add(133, 1, 0, 0, 0, 0, 0, 2);

    foreach (vecs[i]) begin
      goto(vecs[i].cyc - 1);
      enable    = vecs[i].en;
      pulso_raw = vecs[i].raw;
      tick();
      chk("vec_level", {1'b0, pulse_level}, {1'b0, vecs[i].lvl});
      chk("vec_beat",  {1'b0, beat},        {1'b0, vecs[i].bt});
      chk("vec_rej",   {1'b0, rejected},    {1'b0, vecs[i].rj});
      chk("vec_lost",  {1'b0, lost},        {1'b0, vecs[i].ls});
      chk("vec_state", state_dbg,           vecs[i].st);
    end

    run_trio(10, 25, 1'b0, 1'b1, 2'b10);
    run_trio(20, 30, 1'b0, 1'b1, 2'b01);
    run_trio(21, 31, 1'b1, 1'b0, 2'b10);

    // Asynchronous reset in the middle of a refractory window.
    goto(e + REFR + 6);
    r = e + 1;
    pulso_raw = 1'b1;
    goto(r + 3);
    pulso_raw = 1'b0;
    goto(r + 8);
    chk("pre_rst_state", state_dbg, 2'b10);
    #3 rst = 1'b0;
    #1;
    chk("arst_level", {1'b0, pulse_level}, 2'b00);
    chk("arst_beat",  {1'b0, beat},        2'b00);
    chk("arst_rej",   {1'b0, rejected},    2'b00);
    chk("arst_lost",  {1'b0, lost},        2'b00);
    chk("arst_state", state_dbg,           2'b00);
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_state", state_dbg, 2'b01);
    pulso_raw = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (beat === 1'b1) begin
        found = 1'b1;
        lat = i;
      end
    end
    chk_int("reset_latency", lat, 7);
    pulso_raw = 1'b0;

    // enable drop inside REFRACT, then a pulse while disabled.
    tick();
    tick();
    enable = 1'b0;
    tick();
    chk("drop_state", state_dbg, 2'b00);
    chk("drop_lost",  {1'b0, lost}, 2'b00);
    goto(e + 8);
    r = e + 1;
    for (int k = r; k < r + 16; k++) begin
      pulso_raw = (k < r + 8);
      tick();
      chk("dis_beat", {1'b0, beat},     2'b00);
      chk("dis_rej",  {1'b0, rejected}, 2'b00);
      if (k == r + 5) chk("dis_level", {1'b0, pulse_level}, 2'b01);
    end
    pulso_raw = 1'b0;
    enable = 1'b1;
    goto(e + TMO + 3);
    chk("timeout_lost", {1'b0, lost}, 2'b01);
    enable = 1'b0;
    tick();
    chk("disable_clears_lost", {1'b0, lost}, 2'b00);
    enable = 1'b1;

    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pulso_raw = ~pulso_raw;
        hold = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 150))
                                            : int'($urandom_range(1, 10));
      end
      hold--;
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
